// File: rtl/pfd_lock_detect.sv
// pfd_lock_detect: sampled phase-frequency detector with lock qualifier.
// Compares rising edges of ref_in and fb_in after synchronisation into clk.
// Drives up/dn while one edge waits for its partner, and reports a signed
// phase error (in clk cycles) with optional cycle-slip flag. After LOCK_COUNT
// consecutive in-tolerance comparisons it asserts locked.
module pfd_lock_detect #(
  parameter int CNT_W      = 8,
  parameter int TOL        = 2,
  parameter int LOCK_COUNT = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ref_in,
  input  logic                    fb_in,
  output logic                    up,
  output logic                    dn,
  output logic signed [CNT_W-1:0] phase_err,
  output logic                    err_valid,
  output logic                    slip,
  output logic                    locked
);

  // Lead magnitude uses one bit less than the error word, so saturating it at
  // all-ones gives exactly +/-(2^(CNT_W-1)-1) after sign attachment.
  localparam int               MAG_W      = CNT_W - 1;
  localparam logic [MAG_W-1:0] MAG_MAX    = '1;
  localparam logic [MAG_W-1:0] MAG_ONE    = MAG_W'(1);
  localparam logic [7:0]       LK_TARGET  = 8'(LOCK_COUNT);
  localparam logic [CNT_W-1:0] TOL_W      = CNT_W'(TOL);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REF_LEAD = 2'd1,
    FB_LEAD  = 2'd2
  } state_t;

  // Bit 0 carries the reference, bit 1 the feedback.
  logic [1:0] raw_in;
  logic [1:0] sync1_reg;
  logic [1:0] sync2_reg;
  logic [1:0] prev_reg;
  logic [1:0] armed_reg;
  logic [1:0] warm_reg;
  logic [1:0] edge_pulse;
  logic       ref_e;
  logic       fb_e;

  state_t           state_reg;
  logic [MAG_W-1:0] lead_reg;
  logic [MAG_W-1:0] lead_inc;
  logic signed [CNT_W-1:0] lead_pos;
  logic signed [CNT_W-1:0] lead_neg;

  logic [CNT_W-1:0] err_abs;
  logic             good_cmp;
  logic [7:0]       lk_reg;
  logic [7:0]       lk_next;

  assign raw_in = {fb_in, ref_in};

  // warm_reg[1] goes high once sync2_reg holds a genuine post-reset sample,
  // so the reset value of the synchronizer is never mistaken for a low level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      warm_reg <= '0;
    end else begin
      warm_reg <= {warm_reg[0], 1'b1};
    end
  end

  // Two-flop synchronizers, edge-history flop and per-input arming. An input
  // is armed only after it has been seen low, so a level already high at
  // reset release never produces an edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
      prev_reg  <= '0;
      armed_reg <= '0;
    end else begin
      sync1_reg <= raw_in;
      sync2_reg <= sync1_reg;
      prev_reg  <= sync2_reg;
      armed_reg <= armed_reg | ({2{warm_reg[1]}} & ~sync2_reg);
    end
  end

  // Single-cycle rising-edge pulses per input.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_edge
      assign edge_pulse[gi] = sync2_reg[gi] & ~prev_reg[gi] & armed_reg[gi];
    end
  endgenerate

  assign ref_e = edge_pulse[0];
  assign fb_e  = edge_pulse[1];

  // Saturating lead count and its signed forms for emission.
  assign lead_inc = (lead_reg == MAG_MAX) ? lead_reg : lead_reg + MAG_ONE;
  assign lead_pos = {1'b0, lead_reg};
  assign lead_neg = -lead_pos;

  // Phase comparison FSM with registered up/dn and error strobe outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      lead_reg  <= '0;
      up        <= 1'b0;
      dn        <= 1'b0;
      phase_err <= '0;
      err_valid <= 1'b0;
      slip      <= 1'b0;
    end else begin
      err_valid <= 1'b0;
      slip      <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (ref_e && fb_e) begin
            phase_err <= '0;
            err_valid <= 1'b1;
          end else if (ref_e) begin
            state_reg <= REF_LEAD;
            lead_reg  <= MAG_ONE;
            up        <= 1'b1;
          end else if (fb_e) begin
            state_reg <= FB_LEAD;
            lead_reg  <= MAG_ONE;
            dn        <= 1'b1;
          end
        end
        REF_LEAD: begin
          if (ref_e || fb_e) begin
            phase_err <= lead_pos;
            err_valid <= 1'b1;
            if (ref_e) begin
              // A new ref edge always opens the next measurement; it is a
              // slip only when no feedback edge closed the current one.
              slip     <= !fb_e;
              lead_reg <= MAG_ONE;
            end else begin
              state_reg <= IDLE;
              lead_reg  <= '0;
              up        <= 1'b0;
            end
          end else begin
            lead_reg <= lead_inc;
          end
        end
        FB_LEAD: begin
          if (ref_e || fb_e) begin
            phase_err <= lead_neg;
            err_valid <= 1'b1;
            if (fb_e) begin
              slip     <= !ref_e;
              lead_reg <= MAG_ONE;
            end else begin
              state_reg <= IDLE;
              lead_reg  <= '0;
              dn        <= 1'b0;
            end
          end else begin
            lead_reg <= lead_inc;
          end
        end
        default: begin
          state_reg <= IDLE;
          lead_reg  <= '0;
          up        <= 1'b0;
          dn        <= 1'b0;
        end
      endcase
    end
  end

  // Qualification of the most recent comparison and next qualifier count.
  always_comb begin
    err_abs  = phase_err[CNT_W-1] ? CNT_W'(-phase_err) : CNT_W'(phase_err);
    good_cmp = (err_abs <= TOL_W) && !slip;
    lk_next  = (lk_reg >= LK_TARGET) ? LK_TARGET : lk_reg + 8'd1;
  end

  // Lock qualifier: consecutive good comparisons, cleared by any bad one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lk_reg <= '0;
      locked <= 1'b0;
    end else if (err_valid) begin
      if (good_cmp) begin
        lk_reg <= lk_next;
        locked <= (lk_next == LK_TARGET);
      end else begin
        lk_reg <= '0;
        locked <= 1'b0;
      end
    end
  end

endmodule
